// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register word offsets,
// STATUS bit positions, shifter state encoding and the reset divisor.
package uart_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_DIV    = 2'd2;

    localparam int unsigned ST_FULL    = 0;
    localparam int unsigned ST_EMPTY   = 1;
    localparam int unsigned ST_BUSY    = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 8;

    localparam logic [15:0] DEFAULT_DIV = 16'd868;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an exact occupancy count.
// Pushes while full are dropped; the caller observes full_o to flag overflow.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a same-cycle pop never frees room.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode on the CPU data port,
// a TX FIFO, and a shifter FSM driving a registered txd.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic        sel,
    output logic        txd
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    off;
    logic          wr_en;
    logic          push;
    logic          pop;
    logic          ovf_clr;
    logic          busy;
    logic          bit_done;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [31:0]   count_ext;
    logic [31:0]   status;
    logic [15:0]   eff_div_new;
    logic          unused_bits;

    logic [15:0]   div_q, div_d;
    logic          ovf_q, ovf_d;
    tx_state_e     state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic [15:0]   timer_q;
    logic [15:0]   eff_div_q;
    logic          txd_q;

    assign sel     = (daddr[31:4] == BASE_ADDR[31:4]);
    assign off     = daddr[3:2];
    assign wr_en   = sel && (dwe != '0);
    assign push    = wr_en && (off == OFF_TXDATA) && dwe[0];
    assign ovf_clr = wr_en && (off == OFF_STATUS) && dwe[0] && dwdata[ST_OVF];

    assign busy        = (state_q != IDLE);
    assign bit_done    = (timer_q == '0);
    assign eff_div_new = (div_q == '0) ? 16'd1 : div_q;
    assign pop = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (dwdata[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign count_ext = 32'(fifo_count);

    always_comb begin
        status                             = '0;
        status[ST_FULL]                    = fifo_full;
        status[ST_EMPTY]                   = fifo_empty;
        status[ST_BUSY]                    = busy;
        status[ST_OVF]                     = ovf_q;
        status[ST_CNT_LSB+3:ST_CNT_LSB]    = count_ext[3:0];
    end

    always_comb begin
        drdata = '0;
        if (sel) begin
            case (off)
                OFF_STATUS: drdata = status;
                OFF_DIV:    drdata = {16'h0000, div_q};
                default:    drdata = '0;
            endcase
        end
    end

    // A rejected push is applied after the clear so that set wins.
    always_comb begin
        div_d = div_q;
        if (wr_en && (off == OFF_DIV)) begin
            if (dwe[0]) div_d[7:0]  = dwdata[7:0];
            if (dwe[1]) div_d[15:8] = dwdata[15:8];
        end
        ovf_d = ovf_q;
        if (ovf_clr)              ovf_d = 1'b0;
        if (push && fifo_full)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= DEFAULT_DIV;
            ovf_q <= 1'b0;
        end else begin
            div_q <= div_d;
            ovf_q <= ovf_d;
        end
    end

    // txd is a register of the current state's line level, so it trails state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            eff_div_q <= 16'd1;
            txd_q     <= 1'b1;
        end else begin
            txd_q <= (state_q == START) ? 1'b0 :
                     (state_q == DATA)  ? shift_q[0] : 1'b1;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q   <= fifo_rdata;
                        eff_div_q <= eff_div_new;
                        timer_q   <= eff_div_new - 16'd1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        timer_q   <= eff_div_q - 16'd1;
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        timer_q   <= eff_div_q - 16'd1;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= STOP;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift_q   <= fifo_rdata;
                            eff_div_q <= eff_div_new;
                            timer_q   <= eff_div_new - 16'd1;
                            state_q   <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign txd = txd_q;

    assign unused_bits = ^{dwdata[31:16], daddr[1:0], count_ext[31:4]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, framing, FIFO full/overflow,
// back-to-back frames, zero divisor, mid-frame reset and address decode.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam logic [31:0] A_TX  = BASE + 32'h0;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_DIV = BASE + 32'h8;
    localparam logic [31:0] A_RSV = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] daddr = A_ST;
    logic [31:0] dwdata = '0;
    logic [3:0]  dwe = '0;
    logic [31:0] drdata;
    logic        sel;
    logic        txd;
    logic [31:0] rd;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .daddr  (daddr),
        .dwdata (dwdata),
        .dwe    (dwe),
        .drdata (drdata),
        .sel    (sel),
        .txd    (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        daddr  = addr;
        dwdata = data;
        dwe    = be;
        @(posedge clk);
        #1;
        dwe    = '0;
        dwdata = '0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        daddr = addr;
        dwe   = '0;
        #1;
        data = drdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Line level at sample k (k=0 is the negedge right after the push edge);
    // the line leaves idle two samples after the push, one frame of 10*d per byte.
    function automatic logic exp_txd(input int k, input int d, input int n,
                                     input logic [7:0] b0, input logic [7:0] b1);
        int idx, fr, bp;
        logic [7:0] b;
        if (k < 2) return 1'b1;
        idx = (k - 2) / d;
        fr  = idx / 10;
        bp  = idx % 10;
        if (fr >= n) return 1'b1;
        b = (fr == 0) ? b0 : b1;
        if (bp == 0) return 1'b0;
        if (bp == 9) return 1'b1;
        return b[bp-1];
    endfunction

    task automatic watch(input string tag, input int k0, input int ncyc, input int d,
                         input int n, input logic [7:0] b0, input logic [7:0] b1);
        logic exp_busy;
        daddr = A_ST;
        for (int k = k0; k < k0 + ncyc; k++) begin
            @(negedge clk);
            exp_busy = (k >= 1) && (k <= 10 * d * n);
            chk($sformatf("%s_txd[%0d]", tag, k), {31'b0, txd}, {31'b0, exp_txd(k, d, n, b0, b1)});
            chk($sformatf("%s_busy[%0d]", tag, k), {31'b0, drdata[2]}, {31'b0, exp_busy});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_txd", {31'b0, txd}, 32'd1);
        bus_rd(A_ST, rd);   chk("rst_status", rd, 32'h0000_0002);
        chk("rst_sel", {31'b0, sel}, 32'd1);
        bus_rd(A_DIV, rd);  chk("rst_div", rd, 32'h0000_0364);
        bus_rd(A_TX, rd);   chk("rst_txdata_rd", rd, 32'h0);
        bus_rd(A_RSV, rd);  chk("rst_rsv_rd", rd, 32'h0);

        // Single frame 0x55, divisor 4.
        bus_wr(A_DIV, 32'h0000_0004, 4'b0011);
        bus_wr(A_TX, 32'h0000_0055, 4'b0001);
        watch("t1", 0, 46, 4, 1, 8'h55, 8'h00);

        // Fill FIFO while one frame is in flight, then overflow and clear.
        bus_wr(A_DIV, 32'd100, 4'b0011);
        for (int i = 0; i < 9; i++) bus_wr(A_TX, 32'(i + 1), 4'b0001);
        bus_rd(A_ST, rd);   chk("fill_status", rd, 32'h0000_0805);
        bus_wr(A_TX, 32'h0000_00EE, 4'b0001);
        bus_rd(A_ST, rd);   chk("ovf_status", rd, 32'h0000_080D);
        bus_wr(A_ST, 32'h0000_0008, 4'b0001);
        bus_rd(A_ST, rd);   chk("ovf_clr_status", rd, 32'h0000_0805);
        do_reset();
        bus_rd(A_ST, rd);   chk("post_rst_status", rd, 32'h0000_0002);

        // Two queued bytes must come out with no idle gap.
        bus_wr(A_DIV, 32'd2, 4'b0011);
        bus_wr(A_TX, 32'h0000_00A5, 4'b0001);
        bus_wr(A_TX, 32'h0000_003C, 4'b0001);
        watch("t3", 1, 45, 2, 2, 8'hA5, 8'h3C);

        // Divisor 0 behaves as 1.
        bus_wr(A_DIV, 32'h0, 4'b0011);
        bus_rd(A_DIV, rd);  chk("div0_rd", rd, 32'h0);
        bus_wr(A_TX, 32'h0000_00FF, 4'b0001);
        watch("t4", 0, 14, 1, 1, 8'hFF, 8'h00);

        // Out-of-window accesses touch nothing.
        daddr = 32'hFFFF_0010; dwdata = 32'h1234_5678; dwe = 4'hF; #1;
        chk("oow1_sel", {31'b0, sel}, 32'd0);
        chk("oow1_rd", drdata, 32'h0);
        @(posedge clk); #1; dwe = '0;
        daddr = 32'h0000_0004; dwdata = 32'h0000_0008; dwe = 4'hF; #1;
        chk("oow2_sel", {31'b0, sel}, 32'd0);
        chk("oow2_rd", drdata, 32'h0);
        @(posedge clk); #1; dwe = '0;
        bus_rd(A_DIV, rd);  chk("oow_div", rd, 32'h0);
        bus_rd(A_ST, rd);   chk("oow_status", rd, 32'h0000_0002);

        // Divisor byte lanes and reserved writes.
        bus_wr(A_DIV, 32'h1234_AB00, 4'b0010);
        bus_rd(A_DIV, rd);  chk("div_lane1", rd, 32'h0000_AB00);
        bus_wr(A_DIV, 32'hFFFF_FF07, 4'b1101);
        bus_rd(A_DIV, rd);  chk("div_lane0", rd, 32'h0000_AB07);
        bus_wr(A_RSV, 32'hFFFF_FFFF, 4'hF);
        bus_rd(A_DIV, rd);  chk("rsv_div", rd, 32'h0000_AB07);
        bus_rd(A_RSV, rd);  chk("rsv_rd", rd, 32'h0);
        bus_rd(A_ST, rd);   chk("rsv_status", rd, 32'h0000_0002);

        // Reset during DATA with three bytes still queued.
        bus_wr(A_DIV, 32'd4, 4'b0011);
        bus_wr(A_TX, 32'h11, 4'b0001);
        bus_wr(A_TX, 32'h22, 4'b0001);
        bus_wr(A_TX, 32'h33, 4'b0001);
        bus_wr(A_TX, 32'h44, 4'b0001);
        repeat (8) @(posedge clk);
        #1;
        bus_rd(A_ST, rd);   chk("mid_status", rd, 32'h0000_0304);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_txd", {31'b0, txd}, 32'd1);
        bus_rd(A_ST, rd);   chk("mid_rst_status", rd, 32'h0000_0002);
        @(posedge clk); #1;
        reset = 1'b0;
        bus_rd(A_DIV, rd);  chk("mid_rst_div", rd, 32'h0000_0364);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data port: daddr, dwdata and dwe in, drdata out.
- Decodes a 16-byte window at BASE_ADDR.
- Buffers bytes written by software in a FIFO and serializes them 8N1 on txd.
- The top level muxes its drdata onto the CPU read path when sel=1, otherwise uses the data RAM.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, base of the register window (16-byte aligned).
- FIFO_DEPTH, 8, TX FIFO entries (power of 2, at least 2).
- DEFAULT_DIV, 16'd868, divisor loaded at reset (clk cycles per bit).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- daddr  in  32  CPU data address
- dwdata  in  32  CPU write data
- dwe  in  4  CPU byte write enables (bit i enables byte i)
- drdata  out  32  read data for the decoded register; 0 when sel=0
- sel  out  1  daddr lies within [BASE_ADDR, BASE_ADDR+15]
- txd  out  1  serial output, idle high

Behaviour:
- Reset values:
  - txd=1, FIFO empty, state IDLE, divisor=DEFAULT_DIV, overflow=0.
  - sel and drdata are combinational and are not reset.
- Register map (offset: meaning):
  - 0x0 TXDATA, write-only, reads as 0. A write with dwe[0]=1 pushes dwdata[7:0]. dwe[3:1] are ignored.
  - 0x4 STATUS:
    - bit0 full, bit1 empty, bit2 busy (state != IDLE), bit3 overflow (sticky).
    - bits[11:8] FIFO count, zero-extended.
    - Writing with dwe[0]=1 and dwdata[3]=1 clears overflow. All other bits are read-only.
  - 0x8 DIVISOR, R/W, 16 bits in [15:0]. Byte lanes dwe[0] and dwe[1] update their bytes independently. Upper bits read 0.
  - 0xC reserved: reads 0, writes are ignored.
- Decode:
  - The hit check uses daddr[31:4]==BASE_ADDR[31:4]; the offset is daddr[3:2].
  - Writes take effect at the posedge where dwe!=0 and sel=1.
  - A write is one cycle long because the CPU is single-cycle.
- FIFO:
  - Push is rejected when the registered full flag is 1, even if a pop occurs in the same cycle. A rejected push sets overflow.
  - Pointers wrap modulo FIFO_DEPTH.
  - The count is exact from 0 to FIFO_DEPTH.
- Shifter FSM, states IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is non-empty, pop into the shift register, latch eff_div = (divisor==0 ? 1 : divisor), go to START. The pop happens at the edge after the push edge at the earliest.
  - START: txd=0 for eff_div cycles, then DATA.
  - DATA: txd=shift[0] for eff_div cycles per bit, 8 bits, LSB first. A 3-bit bit counter advances the bit.
  - STOP: txd=1 for eff_div cycles. At the end of STOP, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
  - The bit timer is a 16-bit down-counter reloaded at each bit boundary.
  - A divisor written mid-frame takes effect only at the next frame start.
  - txd is registered. Frame length is 10*eff_div cycles.
- Simultaneous events:
  - A push and a pop in the same cycle leave the count unchanged.
  - An overflow-clear and a rejected push in the same cycle leave overflow=1 (set wins).
- Reset mid-frame: txd=1 from the following edge, and FIFO contents are discarded.

Decomposition:
- Shared package uart_pkg holds:
  - register offsets OFF_TXDATA, OFF_STATUS, OFF_DIV
  - STATUS bit indices
  - the FSM state enum (IDLE, START, DATA, STOP)
  - DEFAULT_DIV
- Natural sub-module: sync_fifo, a parameterized width/depth FIFO with push, pop, full, empty and count. It is reusable for a future RX path.
- The shifter FSM and register decode stay in mmio_uart_tx.

Test Plan:
- Reset, then DIV=4, write 0x55 to TXDATA:
  - txd is low for 4 cycles from the edge after the pop.
  - Then data bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles.
  - busy=1 for exactly 40 cycles.
- Write 9 bytes back-to-back while IDLE with DIV=100:
  - 1 byte is popped and 8 fill the FIFO; STATUS reads full=1, count=8.
  - A 10th write sets overflow=1.
  - Writing 0x8 to STATUS clears overflow and leaves count unchanged.
- Two queued bytes 0xA5, 0x3C with DIV=2:
  - Frames are contiguous: the stop bit of 0xA5 is immediately followed by the start bit of 0x3C.
  - Total busy time is 40 cycles.
- Write DIVISOR=0, then byte 0xFF: each bit lasts 1 cycle, frame is 10 cycles, and DIVISOR reads back 0.
- Assert reset during DATA of a frame with 3 bytes queued: txd=1 the next cycle, and STATUS reads empty=1, busy=0, count=0.
- Access daddr=0xFFFF_0010 and 0x0000_0004 with dwe=4'hF: sel=0 and drdata=0, with no FIFO or divisor change.
